// File: rtl/gb_save_uploader.sv
// rtl/gb_save_uploader.sv - streams battery-backed cart RAM from SDRAM to the HPS ioctl upload port
module gb_save_uploader #(
    parameter logic [23:0] RAM_BASE     = 24'h100000,
    parameter int          ACCESS_SYNCS = 2
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [7:0]  cart_ram_size,
    input  logic        ioctl_upload,
    input  logic        ioctl_rd,
    input  logic [24:0] ioctl_addr,
    output logic [15:0] ioctl_din,
    output logic        ioctl_wait,
    output logic [17:0] save_size,
    input  logic        sdram_sync,
    output logic        sdram_oe,
    output logic [23:0] sdram_addr,
    input  logic [15:0] sdram_dout,
    output logic        busy
);

    localparam int CW = (ACCESS_SYNCS > 1) ? $clog2(ACCESS_SYNCS) : 1;
    localparam logic [CW-1:0] LAST_SYNC = CW'(ACCESS_SYNCS - 1);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DONE
    } state_t;

    state_t        state;
    logic [CW-1:0] sync_cnt;
    logic [23:0]   word_addr;
    logic          in_range;
    logic          unused_addr_lsb;

    always_comb begin
        save_size = 18'd0;
        case (cart_ram_size)
            8'd1:    save_size = 18'd2048;
            8'd2:    save_size = 18'd8192;
            8'd3:    save_size = 18'd32768;
            8'd4:    save_size = 18'd131072;
            8'd5:    save_size = 18'd65536;
            default: save_size = 18'd0;
        endcase
    end

    // The HPS addresses bytes; SDRAM holds 16-bit words, so bit 0 carries no information.
    assign word_addr       = ioctl_addr[24:1];
    assign unused_addr_lsb = ioctl_addr[0];
    assign in_range        = {word_addr, 1'b0} < {7'd0, save_size};
    assign busy            = (state != IDLE);

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            ioctl_din  <= 16'h0000;
            ioctl_wait <= 1'b0;
            sdram_oe   <= 1'b0;
            sdram_addr <= RAM_BASE;
            sync_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ioctl_upload && ioctl_rd) begin
                        if (in_range) begin
                            state      <= FETCH;
                            ioctl_wait <= 1'b1;
                            sdram_oe   <= 1'b1;
                            sdram_addr <= RAM_BASE + word_addr;
                            sync_cnt   <= '0;
                        end else begin
                            // Reads past the end of the save return erased-flash style data.
                            ioctl_din <= 16'hFFFF;
                            state     <= DONE;
                        end
                    end
                end
                FETCH: begin
                    if (!ioctl_upload) begin
                        sdram_oe   <= 1'b0;
                        ioctl_wait <= 1'b0;
                        state      <= IDLE;
                    end else if (sdram_sync) begin
                        if (sync_cnt == LAST_SYNC) begin
                            ioctl_din  <= sdram_dout;
                            sdram_oe   <= 1'b0;
                            ioctl_wait <= 1'b0;
                            state      <= DONE;
                        end else begin
                            sync_cnt <= sync_cnt + CW'(1);
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state      <= IDLE;
                    sdram_oe   <= 1'b0;
                    ioctl_wait <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gb_save_uploader.sv
// tb/tb_gb_save_uploader.sv - scoreboard bench for gb_save_uploader
module tb_gb_save_uploader;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic [7:0]  cart_ram_size;
    logic        ioctl_upload;
    logic        ioctl_rd;
    logic [24:0] ioctl_addr;
    logic [15:0] ioctl_din;
    logic        ioctl_wait;
    logic [17:0] save_size;
    logic        sdram_sync;
    logic        sdram_oe;
    logic [23:0] sdram_addr;
    logic [15:0] sdram_dout;
    logic        busy;

    gb_save_uploader dut (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .cart_ram_size(cart_ram_size),
        .ioctl_upload (ioctl_upload),
        .ioctl_rd     (ioctl_rd),
        .ioctl_addr   (ioctl_addr),
        .ioctl_din    (ioctl_din),
        .ioctl_wait   (ioctl_wait),
        .save_size    (save_size),
        .sdram_sync   (sdram_sync),
        .sdram_oe     (sdram_oe),
        .sdram_addr   (sdram_addr),
        .sdram_dout   (sdram_dout),
        .busy         (busy)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        logic [15:0] din;
        logic [23:0] addr;
        logic        touched;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   done_cnt = 0;
    logic fast_sync = 1'b0;

    function automatic logic [15:0] model_word(input logic [23:0] a);
        logic [23:0] off;
        off = a - 24'h100000;
        if (a == 24'h100010) return 16'hBEEF;
        return off[15:0] + 16'h0100;
    endfunction

    always_comb sdram_dout = model_word(sdram_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    initial begin
        int sc = 0;
        sdram_sync = 1'b0;
        forever begin
            @(negedge clk_sys);
            sc++;
            sdram_sync = fast_sync ? 1'b1 : ((sc % 8) == 0);
        end
    end

    // Monitor: tracks the SDRAM side of each fetch and pops the scoreboard in DONE.
    initial begin
        logic        prev_oe = 1'b0;
        logic        oe_seen = 1'b0;
        logic        wait_seen = 1'b0;
        int          syncs = 0;
        int          addr_moves = 0;
        logic [23:0] first_addr = '0;
        exp_t        e;
        forever begin
            @(posedge clk_sys);
            #1;
            if (!busy) begin
                oe_seen = 0; wait_seen = 0; syncs = 0; addr_moves = 0;
            end else begin
                if (prev_oe && sdram_sync) syncs++;
                if (sdram_oe) begin
                    if (!oe_seen) first_addr = sdram_addr;
                    else if (sdram_addr != first_addr) addr_moves++;
                    oe_seen = 1;
                end
                if (ioctl_wait) wait_seen = 1;
                if (!ioctl_wait) begin
                    done_cnt++;
                    if (q.size() == 0) begin
                        chk("unexpected_done", 1, 0);
                    end else begin
                        e = q.pop_front();
                        chk("din", ioctl_din, e.din);
                        chk("oe_low_in_done", sdram_oe, 0);
                        if (e.touched) begin
                            chk("oe_seen", oe_seen, 1);
                            chk("oe_syncs", syncs, 2);
                            chk("sdram_addr", first_addr, e.addr);
                            chk("addr_stable", addr_moves, 0);
                        end else begin
                            chk("no_oe", oe_seen, 0);
                            chk("no_wait", wait_seen, 0);
                        end
                    end
                end
            end
            prev_oe = sdram_oe;
        end
    end

    task automatic do_read(input logic [24:0] a, output int lat, output logic w1);
        int g;
        @(negedge clk_sys);
        ioctl_upload = 1'b1;
        ioctl_rd     = 1'b1;
        ioctl_addr   = a;
        @(negedge clk_sys);
        ioctl_rd = 1'b0;
        w1  = ioctl_wait;
        lat = 1;
        while (ioctl_wait && lat < 40) begin
            @(negedge clk_sys);
            lat++;
        end
        g = 0;
        while (busy && g < 40) begin
            @(negedge clk_sys);
            g++;
        end
        if (lat >= 40 || g >= 40) chk("read_timeout", 1, 0);
    endtask

    task automatic push(input logic [15:0] d, input logic [23:0] a, input logic t);
        exp_t e;
        e.din = d; e.addr = a; e.touched = t;
        q.push_back(e);
    endtask

    logic [7:0]  size_in [7] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'h07};
    logic [17:0] size_out[7] = '{18'd0, 18'd2048, 18'd8192, 18'd32768, 18'd131072, 18'd65536, 18'd0};

    initial begin
        int   lat;
        int   g;
        int   dc0;
        logic w1;
        reset = 1'b1; cart_ram_size = 8'd0; ioctl_upload = 1'b0;
        ioctl_rd = 1'b0; ioctl_addr = '0;
        repeat (3) @(negedge clk_sys);
        reset = 1'b0;
        @(negedge clk_sys);
        chk("rst_din", ioctl_din, 16'h0000);
        chk("rst_wait", ioctl_wait, 0);
        chk("rst_oe", sdram_oe, 0);
        chk("rst_addr", sdram_addr, 24'h100000);
        chk("rst_busy", busy, 0);

        for (int i = 0; i < 7; i++) begin
            cart_ram_size = size_in[i];
            #1;
            chk("save_size", save_size, size_out[i]);
        end

        // Upload and rd rise together; slow sync cadence.
        cart_ram_size = 8'd3;
        push(16'hBEEF, 24'h100010, 1);
        do_read(25'h20, lat, w1);
        chk("beef_wait_next", w1, 1);
        chk("beef_latency_le17", lat <= 17, 1);

        cart_ram_size = 8'd2;
        push(16'hFFFF, 24'h0, 0);
        do_read(25'h2000, lat, w1);
        chk("oor_wait_low", w1, 0);

        cart_ram_size = 8'd3;
        fast_sync = 1'b1;
        for (int b = 0; b < 32'h8000; b += 2) begin
            push(model_word(24'h100000 + 24'(b >> 1)), 24'h100000 + 24'(b >> 1), 1);
            do_read(25'(b), lat, w1);
        end
        push(16'hFFFF, 24'h0, 0);
        do_read(25'h8000, lat, w1);
        fast_sync = 1'b0;

        // Second rd during FETCH must be dropped.
        repeat (4) @(negedge clk_sys);
        dc0 = done_cnt;
        push(16'h0120, 24'h100020, 1);
        ioctl_rd = 1'b1; ioctl_addr = 25'h40;
        @(negedge clk_sys);
        ioctl_rd = 1'b0;
        @(negedge clk_sys);
        chk("mid_in_fetch", ioctl_wait, 1);
        ioctl_rd = 1'b1; ioctl_addr = 25'h80;
        @(negedge clk_sys);
        ioctl_rd = 1'b0;
        g = 0;
        while (busy && g < 40) begin @(negedge clk_sys); g++; end
        repeat (30) @(negedge clk_sys);
        chk("one_fetch_only", done_cnt - dc0, 1);

        // Abort by dropping upload.
        ioctl_rd = 1'b1; ioctl_addr = 25'h60;
        @(negedge clk_sys);
        ioctl_rd = 1'b0;
        chk("abort_in_fetch", ioctl_wait, 1);
        ioctl_upload = 1'b0;
        @(posedge clk_sys);
        #1;
        chk("abort_oe", sdram_oe, 0);
        chk("abort_wait", ioctl_wait, 0);
        chk("abort_busy", busy, 0);
        chk("abort_din", ioctl_din, 16'h0120);

        // Asynchronous reset mid-fetch.
        @(negedge clk_sys);
        ioctl_upload = 1'b1; ioctl_rd = 1'b1; ioctl_addr = 25'h10;
        @(negedge clk_sys);
        ioctl_rd = 1'b0;
        chk("reset_in_fetch", ioctl_wait, 1);
        #2 reset = 1'b1;
        #1;
        chk("arst_din", ioctl_din, 16'h0000);
        chk("arst_wait", ioctl_wait, 0);
        chk("arst_oe", sdram_oe, 0);
        chk("arst_addr", sdram_addr, 24'h100000);
        chk("arst_busy", busy, 0);
        @(negedge clk_sys);
        reset = 1'b0;
        repeat (20) @(negedge clk_sys);
        chk("queue_empty", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
